// File: rtl/serial_dft_mc.sv
// Multi-channel serial single-bin DFT: per-lane complex MAC over a frame, with a
// one-deep output holding register. Define SERIAL_DFT_MC_SAT_EN for saturating narrowing and sat_o.
module serial_dft_mc_lane #(
    parameter int X_WIDTH   = 16,
    parameter int W_WIDTH   = 16,
    parameter int S_WIDTH   = 40,
    parameter int O_WIDTH   = 32,
    parameter int OUT_SHIFT = 0
) (
    input  logic               clk,
    input  logic               arstn,
    input  logic               accept,
    input  logic               first,
    input  logic               load,
    input  logic [X_WIDTH-1:0] x,
    input  logic [W_WIDTH-1:0] wr,
    input  logic [W_WIDTH-1:0] wi,
    output logic [O_WIDTH-1:0] re,
    output logic [O_WIDTH-1:0] im
`ifdef SERIAL_DFT_MC_SAT_EN
    ,
    output logic               sat
`endif
);
    logic signed [X_WIDTH+W_WIDTH-1:0] pr, pi;
    logic signed [S_WIDTH-1:0] pr_s, pi_s, base_re, base_im;
    logic signed [S_WIDTH-1:0] acc_re, acc_im, sum_re, sum_im;
    logic [O_WIDTH-1:0] nar_re, nar_im;

    assign pr   = $signed(x) * $signed(wr);
    assign pi   = $signed(x) * $signed(wi);
    assign pr_s = pr;
    assign pi_s = pi;

    // Position 0 restarts the sum, which also makes a flush need no explicit clear
    always_comb begin
        base_re = acc_re;
        base_im = acc_im;
        if (first) begin
            base_re = '0;
            base_im = '0;
        end
    end

    assign sum_re = base_re + pr_s;
    assign sum_im = base_im + pi_s;

`ifdef SERIAL_DFT_MC_SAT_EN
    localparam logic signed [S_WIDTH-1:0] O_MAX =
        {{(S_WIDTH-O_WIDTH+1){1'b0}}, {(O_WIDTH-1){1'b1}}};
    localparam logic signed [S_WIDTH-1:0] O_MIN = ~O_MAX;

    logic signed [S_WIDTH-1:0] sh_re, sh_im;
    logic sat_re, sat_im;

    assign sh_re = sum_re >>> OUT_SHIFT;
    assign sh_im = sum_im >>> OUT_SHIFT;

    always_comb begin
        sat_re = 1'b0;
        sat_im = 1'b0;
        nar_re = sh_re[O_WIDTH-1:0];
        nar_im = sh_im[O_WIDTH-1:0];
        if (sh_re > O_MAX) begin
            nar_re = O_MAX[O_WIDTH-1:0];
            sat_re = 1'b1;
        end else if (sh_re < O_MIN) begin
            nar_re = O_MIN[O_WIDTH-1:0];
            sat_re = 1'b1;
        end
        if (sh_im > O_MAX) begin
            nar_im = O_MAX[O_WIDTH-1:0];
            sat_im = 1'b1;
        end else if (sh_im < O_MIN) begin
            nar_im = O_MIN[O_WIDTH-1:0];
            sat_im = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn)    sat <= 1'b0;
        else if (load) sat <= sat_re | sat_im;
    end
`else
    assign nar_re = O_WIDTH'(sum_re >>> OUT_SHIFT);
    assign nar_im = O_WIDTH'(sum_im >>> OUT_SHIFT);
`endif

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            acc_re <= '0;
            acc_im <= '0;
            re     <= '0;
            im     <= '0;
        end else begin
            if (accept) begin
                acc_re <= sum_re;
                acc_im <= sum_im;
            end
            if (load) begin
                re <= nar_re;
                im <= nar_im;
            end
        end
    end
endmodule

module serial_dft_mc #(
    parameter int N_CH         = 4,
    parameter int X_WIDTH      = 16,
    parameter int W_WIDTH      = 16,
    parameter int S_WIDTH      = 40,
    parameter int O_WIDTH      = 32,
    parameter int OUT_SHIFT    = 0,
    parameter int FRAME_LENGTH = 8
) (
    input  logic                                 clk,
    input  logic                                 arstn,
    input  logic [FRAME_LENGTH-1:0][W_WIDTH-1:0] w_re,
    input  logic [FRAME_LENGTH-1:0][W_WIDTH-1:0] w_im,
    input  logic                                 flush_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic [N_CH-1:0][X_WIDTH-1:0]         x_i,
    output logic [$clog2(FRAME_LENGTH)-1:0]      idx_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [N_CH-1:0][O_WIDTH-1:0]         re_o,
    output logic [N_CH-1:0][O_WIDTH-1:0]         im_o
`ifdef SERIAL_DFT_MC_SAT_EN
    ,
    output logic                                 sat_o
`endif
);
    localparam int IDX_W = $clog2(FRAME_LENGTH);

    typedef enum logic {EMPTY, FULL} state_t;
    state_t state_q, state_d;

    logic [IDX_W-1:0] idx;
    logic first, last, accept, load;

    assign first   = (idx == '0);
    assign last    = (idx == IDX_W'(FRAME_LENGTH-1));
    assign valid_o = (state_q == FULL);
    // Only a frame end into a held, unconsumed result has to stall
    assign ready_o = !(last && valid_o && !ready_i);
    assign accept  = valid_i && ready_o && !flush_i;
    assign load    = accept && last;
    assign idx_o   = idx;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn)       idx <= '0;
        else if (flush_i) idx <= '0;
        else if (accept)  idx <= last ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (load)             state_d = FULL;
            FULL:  if (ready_i && !load) state_d = EMPTY;
            default:                     state_d = EMPTY;
        endcase
    end

`ifdef SERIAL_DFT_MC_SAT_EN
    logic [N_CH-1:0] lane_sat;
    assign sat_o = |lane_sat;
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        serial_dft_mc_lane #(
            .X_WIDTH  (X_WIDTH),
            .W_WIDTH  (W_WIDTH),
            .S_WIDTH  (S_WIDTH),
            .O_WIDTH  (O_WIDTH),
            .OUT_SHIFT(OUT_SHIFT)
        ) u_lane (
            .clk   (clk),
            .arstn (arstn),
            .accept(accept),
            .first (first),
            .load  (load),
            .x     (x_i[c]),
            .wr    (w_re[idx]),
            .wi    (w_im[idx]),
            .re    (re_o[c]),
            .im    (im_o[c])
`ifdef SERIAL_DFT_MC_SAT_EN
            ,
            .sat   (lane_sat[c])
`endif
        );
    end
endmodule

// File: doc/serial_dft_mc.md
# serial_dft_mc

Multi-channel serial single-bin DFT engine: accepts one sample per channel per beat, multiplies by the twiddle for the current frame position, and accumulates complex sums over FRAME_LENGTH beats. At frame end it scales each channel's sum and moves it into an output holding register with a valid/ready handshake. Input backpressure is asserted only when a finished frame cannot be stored. It sits after the sample framer, in place of the fixed two-channel serial DFT node, feeding the spectral post-processing chain.

## Interface
- N_CH, 4: number of parallel sample channels, ≥1
- X_WIDTH, 16: signed sample width
- W_WIDTH, 16: signed twiddle width
- S_WIDTH, 40: signed accumulator width, ≥ X_WIDTH+W_WIDTH
- O_WIDTH, 32: signed output width, ≤ S_WIDTH
- OUT_SHIFT, 0: arithmetic right shift applied at frame end, 0..S_WIDTH-1
- FRAME_LENGTH, 8: samples per frame, ≥2
- clk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- w_re  in  W_WIDTH × FRAME_LENGTH  real twiddles, indexed by frame position
- w_im  in  W_WIDTH × FRAME_LENGTH  imaginary twiddles
- flush_i  in  1  synchronous abort of the current frame
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i & ready_o
- x_i  in  X_WIDTH × N_CH  signed samples, one per channel
- idx_o  out  $clog2(FRAME_LENGTH)  frame position of the next accepted beat
- valid_o  out  1  output holding register full
- ready_i  in  1  downstream accepts the result when valid_o & ready_i
- re_o  out  O_WIDTH × N_CH  real result per channel
- im_o  out  O_WIDTH × N_CH  imaginary result per channel

## Operation
- Position counter `idx` starts at 0 and increments on each accepted beat. It wraps to 0 after FRAME_LENGTH-1. idx_o = idx.
- Per channel c on an accepted beat:
  - pr = x_i[c]·w_re[idx] and pi = x_i[c]·w_im[idx], both full precision, sign-extended to S_WIDTH.
  - If idx==0: acc_re[c] ← pr and acc_im[c] ← pi.
  - Otherwise: acc_re[c] += pr and acc_im[c] += pi, two's-complement wrap in S_WIDTH.
- Frame end is an accepted beat with idx==FRAME_LENGTH-1.
  - On frame end, re_o[c] and im_o[c] are loaded with (acc + p) >>> OUT_SHIFT, narrowed to O_WIDTH; valid_o ← 1.
  - Narrowing is defined under Configuration.
- Output register states: EMPTY (valid_o=0) and FULL (valid_o=1).
  - FULL→EMPTY on ready_i when no frame end occurs in the same cycle.
  - FULL→FULL with new data on ready_i together with a frame end.
- ready_o = !(idx==FRAME_LENGTH-1 & valid_o & !ready_i). Accumulation of non-final beats continues while the output is FULL.
- flush_i (synchronous, highest priority):
  - idx ← 0; accumulators are treated as cleared.
  - A valid_i beat in the same cycle is discarded.
  - Output register and valid_o are unaffected.
- re_o/im_o hold their value while valid_o=0; they are don't-care for checking.

## Timing
- Reset values: idx 0, accumulators 0, valid_o 0, re_o/im_o 0.
- ready_o is 1 out of reset.
- Latency is 1 cycle: valid_o rises on the clock edge that accepts the frame-end beat.
- Throughput is one beat per cycle. Back-to-back frames run with no bubbles while ready_i=1.
- ready_o is combinational from idx, valid_o and ready_i. No other output is combinational from an input.
- Reset mid-frame: the partial frame is lost and the output register is cleared. The next beat after arstn release is position 0.

## Configuration
- SERIAL_DFT_MC_SAT_EN defined:
  - Narrowing saturates to [-2^(O_WIDTH-1), 2^(O_WIDTH-1)-1].
  - sat_o (out, 1) is added; it is 1 when any channel saturated in the held result, and is loaded alongside re_o/im_o.
- Undefined: narrowing keeps the low O_WIDTH bits (wrap), and sat_o is absent.

## Test plan
- N_CH=2, FRAME_LENGTH=4, w_re={1,1,1,1}, w_im={0,-1,0,1}, ch0={1,2,3,4}, ch1={-1,-1,-1,-1}, ready_i=1 -> one cycle after beat 3: valid_o=1, re={10,-4}, im={2,0}.
- Same setup with ready_i=0 for two full frames -> after the first frame valid_o=1. ready_o=0 while idx==3 until ready_i pulses. Frame-2 data replaces frame-1 in the same cycle as the handshake.
- O_WIDTH=16, OUT_SHIFT=0, x=32767, w_re=32767 for all 4 beats (acc=0xFFFC0004) -> with SAT_EN re_o=32767 and sat_o=1; without it re_o=4.
- OUT_SHIFT=2 with the first scenario's data -> re={2,-1}, im={0,0}.
- flush_i at idx=2 together with valid_i, then a fresh 4-beat frame -> the result equals the fresh frame only and the held result is unchanged until then.
- arstn low at idx=2 with valid_o=1 -> valid_o=0, outputs 0, idx_o=0, ready_o=1. The next frame gives correct sums.
